// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scan-out has absolute priority with fixed
// two-cycle latency; CPU accesses are fitted into idle slots, one at a time.
module vram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} busy_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU_RD, TAG_CPU_WR} tag_e;

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  // CPU handshake: cpu_req with addr/we/wdata is held stable until the
  // one-cycle cpu_ack pulse; a request still high the cycle after ack is new.

  busy_e             state_q, state_d;
  tag_e              tag_d, tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_grant;
  logic              starve_clr;

  assign dbg_busy   = (state_q == BUSY);
  assign cpu_grant  = reset && !vga_req && cpu_req && (state_q == IDLE);
  assign starve_clr = !cpu_req || cpu_grant;

  // Slot decision; the address bus parks on its last value in empty slots.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    if (!reset) begin
      mem_addr = '0;
    end else if (vga_req) begin
      mem_addr = vga_addr;
      tag_d    = TAG_VGA;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
      tag_d     = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_grant) state_d = BUSY;
      BUSY:    if (cpu_ack)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (starve_clr) begin
      cnt_d = '0;
    end else if ((state_q == IDLE) && vga_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tag_q      <= TAG_NONE;
      addr_q     <= '0;
      cnt_q      <= '0;
      cpu_starve <= 1'b0;
      vga_valid  <= 1'b0;
      vga_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      addr_q     <= mem_addr;
      cnt_q      <= cnt_d;
      // Flag follows the previous count but drops right after a grant.
      cpu_starve <= starve_clr ? 1'b0 : (cnt_q >= LIMIT_C);
      vga_valid  <= (tag_q == TAG_VGA);
      cpu_ack    <= (tag_q == TAG_CPU_RD) || (tag_q == TAG_CPU_WR);
      if (tag_q == TAG_VGA)    vga_rdata <= mem_rdata;
      if (tag_q == TAG_CPU_RD) cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural VRAM model, one instance at
// default starvation limit and one with STARVE_LIMIT=4 sharing its stimulus.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;

  logic          vga_valid, cpu_ack, cpu_starve, mem_we, dbg_busy;
  logic [DW-1:0] vga_rdata, cpu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          vga_valid2, cpu_ack2, cpu_starve2, mem_we2, dbg_busy2;
  logic [DW-1:0] vga_rdata2, cpu_rdata2, mem_wdata2;
  logic [AW-1:0] mem_addr2;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          init_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_starve(cpu_starve),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_busy(dbg_busy)
  );

  vram_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid2), .vga_rdata(vga_rdata2),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2), .cpu_starve(cpu_starve2),
    .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata),
    .dbg_busy(dbg_busy2)
  );

  // Synchronous single-port RAM, preloaded with RAM[i] = i + 16 for i < 8.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 8; i++) ram[i] <= DW'(i + 16);
      init_done <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Apply one cycle of inputs mid-cycle, then settle for checking.
  task automatic drive(input logic vr, input logic [AW-1:0] va, input logic cr,
                       input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    @(negedge clk);
    vga_req = vr; vga_addr = va; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    #1;
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, "_vga_valid"}, 32'(vga_valid), 0);
    chk({ph, "_vga_rdata"}, 32'(vga_rdata), 0);
    chk({ph, "_cpu_ack"},   32'(cpu_ack), 0);
    chk({ph, "_cpu_rdata"}, 32'(cpu_rdata), 0);
    chk({ph, "_cpu_starve"},32'(cpu_starve), 0);
    chk({ph, "_mem_addr"},  32'(mem_addr), 0);
    chk({ph, "_mem_we"},    32'(mem_we), 0);
    chk({ph, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    chk_all_zero("rst");
    @(negedge clk); reset = 1'b1;

    // VGA stream: addr 0..7 back to back
    for (int c = 0; c <= 10; c++) begin
      drive(c < 8, AW'(c < 8 ? c : 0), 0, 0, 0, 0);
      chk($sformatf("vs_valid_c%0d", c), 32'(vga_valid), 32'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk($sformatf("vs_data_c%0d", c), 32'(vga_rdata), 32'(c + 14));
      chk($sformatf("vs_addr_c%0d", c), 32'(mem_addr), 32'(c < 8 ? c : 7));
      chk($sformatf("vs_we_c%0d", c), 32'(mem_we), 0);
    end
    chk("vs_rdata_hold", 32'(vga_rdata), 32'h17);

    // CPU write 0xA5 to addr 100
    for (int c = 0; c <= 3; c++) begin
      drive(0, 0, c <= 2, 1, 100, 8'hA5);
      chk($sformatf("wr_we_c%0d", c), 32'(mem_we), 32'(c == 0));
      chk($sformatf("wr_ack_c%0d", c), 32'(cpu_ack), 32'(c == 2));
      chk($sformatf("wr_busy_c%0d", c), 32'(dbg_busy), 32'(c == 1 || c == 2));
      chk($sformatf("wr_addr_c%0d", c), 32'(mem_addr), 100);
      if (c == 0) chk("wr_wdata", 32'(mem_wdata), 32'hA5);
    end
    chk("wr_rdata_unchanged", 32'(cpu_rdata), 0);

    // CPU read addr 100
    for (int c = 0; c <= 3; c++) begin
      drive(0, 0, c <= 2, 0, 100, 0);
      chk($sformatf("rd_we_c%0d", c), 32'(mem_we), 0);
      chk($sformatf("rd_ack_c%0d", c), 32'(cpu_ack), 32'(c == 2));
      if (c == 2) chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
    end

    // Contention: VGA cycles 0-4, CPU read addr 5 pending from cycle 0
    for (int c = 0; c <= 8; c++) begin
      drive(c <= 4, AW'(c <= 4 ? c : 0), c <= 7, 0, 5, 0);
      chk($sformatf("ct_valid_c%0d", c), 32'(vga_valid), 32'(c >= 2 && c <= 6));
      if (c >= 2 && c <= 6) chk($sformatf("ct_vdata_c%0d", c), 32'(vga_rdata), 32'(c + 14));
      chk($sformatf("ct_addr_c%0d", c), 32'(mem_addr), 32'(c <= 4 ? c : 5));
      chk($sformatf("ct_ack_c%0d", c), 32'(cpu_ack), 32'(c == 7));
      if (c == 7) chk("ct_rdata", 32'(cpu_rdata), 32'h15);
      chk($sformatf("ct_starve_c%0d", c), 32'(cpu_starve), 0);
      chk($sformatf("ct_starve4_c%0d", c), 32'(cpu_starve2), 32'(c == 5));
    end

    // Starvation: VGA cycles 0-9, CPU read addr 6 pending from cycle 0
    for (int c = 0; c <= 13; c++) begin
      drive(c <= 9, 0, c <= 12, 0, 6, 0);
      chk($sformatf("sv_starve4_c%0d", c), 32'(cpu_starve2), 32'(c >= 5 && c <= 10));
      chk($sformatf("sv_starve_c%0d", c), 32'(cpu_starve), 0);
      chk($sformatf("sv_ack_c%0d", c), 32'(cpu_ack), 32'(c == 12));
      chk($sformatf("sv_ack4_c%0d", c), 32'(cpu_ack2), 32'(c == 12));
      if (c == 12) chk("sv_rdata", 32'(cpu_rdata), 32'h16);
    end

    // Handshake: request held past ack starts a second write at T+3
    ack_cnt = 0;
    for (int c = 0; c <= 8; c++) begin
      drive(0, 0, c <= 5, 1, 200, (c < 3) ? 8'h11 : 8'h22);
      if (cpu_ack) ack_cnt++;
      chk($sformatf("hs_we_c%0d", c), 32'(mem_we), 32'(c == 0 || c == 3));
      chk($sformatf("hs_busy_c%0d", c), 32'(dbg_busy), 32'(c == 1 || c == 2 || c == 4 || c == 5));
      if (c == 3) chk("hs_wdata2", 32'(mem_wdata), 32'h22);
    end
    chk("hs_ack_total", 32'(ack_cnt), 2);

    // Reset mid-burst with a CPU read and VGA fetches in flight
    drive(0, 0, 1, 0, 100, 0);
    drive(1, 1, 1, 0, 100, 0);
    drive(1, 2, 1, 0, 100, 0);
    chk("mr_ack_before", 32'(cpu_ack), 1);
    chk("mr_rdata_before", 32'(cpu_rdata), 32'hA5);
    reset = 1'b0;
    #1;
    chk_all_zero("mr");
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("mr_valid_c%0d", c), 32'(vga_valid), 0);
      chk($sformatf("mr_ack_c%0d", c), 32'(cpu_ack), 0);
      chk($sformatf("mr_busy_c%0d", c), 32'(dbg_busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
